// File: rtl/mole_pkg.sv
// Shared types, default constants and helpers for the mole visibility timer.
package mole_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_CNT_W          = 16;
   localparam int DEF_LVL_W          = 4;
   localparam int DEF_INIT_WINDOW    = 1000;
   localparam int DEF_MIN_WINDOW     = 200;
   localparam int DEF_STEP           = 50;
   localparam int DEF_HITS_PER_LEVEL = 5;

   // Subtract b from a but never go below floor_val; compares before subtracting.
   function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] floor_val);
      if (a < floor_val + b)
         return floor_val;
      return a - b;
   endfunction

endpackage

// File: rtl/mole_difficulty.sv
// Hit counter, difficulty level and the window that the next countdown load uses.
module mole_difficulty
   import mole_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int LVL_W          = DEF_LVL_W,
   parameter int INIT_WINDOW    = DEF_INIT_WINDOW,
   parameter int MIN_WINDOW     = DEF_MIN_WINDOW,
   parameter int STEP           = DEF_STEP,
   parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL
) (
   input  logic             clk_game,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             hit_pulse,
   output logic [CNT_W-1:0] window,
   output logic [LVL_W-1:0] level
);

   localparam int HC_W = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;
   localparam logic [HC_W-1:0] LAST_HIT = HC_W'(HITS_PER_LEVEL - 1);

   logic [HC_W-1:0]  hit_cnt_reg, hit_cnt_next;
   logic [LVL_W-1:0] level_reg, level_next;
   logic [CNT_W-1:0] window_reg, window_next;

   always_comb begin
      hit_cnt_next = hit_cnt_reg;
      level_next   = level_reg;
      window_next  = window_reg;
      if (!enable) begin
         hit_cnt_next = '0;
         level_next   = '0;
         window_next  = CNT_W'(INIT_WINDOW);
      end else if (hit_pulse) begin
         if (hit_cnt_reg == LAST_HIT) begin
            hit_cnt_next = '0;
            if (level_reg != {LVL_W{1'b1}})
               level_next = level_reg + LVL_W'(1);
            window_next = CNT_W'(sat_sub(32'(window_reg), 32'(STEP), 32'(MIN_WINDOW)));
         end else begin
            hit_cnt_next = hit_cnt_reg + HC_W'(1);
         end
      end
   end

   always_ff @(posedge clk_game or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_reg <= '0;
         level_reg   <= '0;
         window_reg  <= CNT_W'(INIT_WINDOW);
      end else begin
         hit_cnt_reg <= hit_cnt_next;
         level_reg   <= level_next;
         window_reg  <= window_next;
      end
   end

   assign window = window_reg;
   assign level  = level_reg;

endmodule

// File: rtl/mole_timer.sv
// Per-mole visibility countdown with hit cancel and timeout pulse.
// Optional MOLE_TIMER_PAUSE_EN adds a pause input that freezes a running countdown.
module mole_timer
   import mole_pkg::*;
#(
   parameter int CNT_W          = DEF_CNT_W,
   parameter int INIT_WINDOW    = DEF_INIT_WINDOW,
   parameter int MIN_WINDOW     = DEF_MIN_WINDOW,
   parameter int STEP           = DEF_STEP,
   parameter int HITS_PER_LEVEL = DEF_HITS_PER_LEVEL,
   parameter int LVL_W          = DEF_LVL_W
) (
   input  logic             clk_game,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             start_timer,
   input  logic             hit_pulse,
`ifdef MOLE_TIMER_PAUSE_EN
   input  logic             pause,
`endif
   output logic             timeout_pulse,
   output logic [CNT_W-1:0] window,
   output logic [LVL_W-1:0] level,
   output logic             running
);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             timeout_reg, timeout_next;
   logic             hold;

`ifdef MOLE_TIMER_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   mole_difficulty #(
      .CNT_W          (CNT_W),
      .LVL_W          (LVL_W),
      .INIT_WINDOW    (INIT_WINDOW),
      .MIN_WINDOW     (MIN_WINDOW),
      .STEP           (STEP),
      .HITS_PER_LEVEL (HITS_PER_LEVEL)
   ) u_difficulty (
      .clk_game  (clk_game),
      .rst_n     (rst_n),
      .enable    (enable),
      .hit_pulse (hit_pulse),
      .window    (window),
      .level     (level)
   );

   // Loads always use the registered window, so a same-cycle hit never affects them.
   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      timeout_next = 1'b0;
      if (!enable) begin
         state_next = IDLE;
         count_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_timer) begin
                  count_next = window - CNT_W'(1);
                  state_next = RUN;
               end
            end
            RUN: begin
               if (hit_pulse) begin
                  state_next = IDLE;
                  count_next = '0;
               end else if (start_timer) begin
                  count_next = window - CNT_W'(1);
               end else if (!hold) begin
                  if (count_reg == '0) begin
                     timeout_next = 1'b1;
                     state_next   = IDLE;
                  end else begin
                     count_next = count_reg - CNT_W'(1);
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_game or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         timeout_reg <= timeout_next;
      end
   end

   assign timeout_pulse = timeout_reg;
   assign running       = (state_reg == RUN);

endmodule

// File: tb/tb_mole_timer.sv
// Scoreboard bench for mole_timer: expected timeout edges are queued at each start.
module tb_mole_timer;

   logic        clk_game = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        start_timer = 1'b0;
   logic        hit_pulse = 1'b0;
   logic        pause = 1'b0;
   logic        timeout_pulse;
   logic [15:0] window;
   logic [3:0]  level;
   logic        running;

   int edge_cnt = 0;
   int n_checks = 0;
   int n_pass = 0;
   int n_timeouts = 0;
   int exp_q[$];

   // Bench's own difficulty model, straight from the rules
   int m_hits = 0;
   int m_level = 0;
   int m_window = 1000;

   always #5 clk_game = ~clk_game;

   mole_timer dut (
      .clk_game      (clk_game),
      .rst_n         (rst_n),
      .enable        (enable),
      .start_timer   (start_timer),
      .hit_pulse     (hit_pulse),
`ifdef MOLE_TIMER_PAUSE_EN
      .pause         (pause),
`endif
      .timeout_pulse (timeout_pulse),
      .window        (window),
      .level         (level),
      .running       (running)
   );

   always @(posedge clk_game) edge_cnt <= edge_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("  ok   %s = %0d", tag, got);
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   always @(negedge clk_game) begin
      if (rst_n && timeout_pulse) begin
         n_timeouts++;
         if (exp_q.size() == 0) begin
            check("spurious_timeout", edge_cnt, 0);
         end else begin
            check("timeout_edge", edge_cnt, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk_game);
      #1;
   endtask

   task automatic model_clear();
      m_hits = 0;
      m_level = 0;
      m_window = 1000;
   endtask

   task automatic pulse_start();
      start_timer = 1'b1;
      step();
      start_timer = 1'b0;
      exp_q.delete();
      exp_q.push_back(edge_cnt + m_window);
      $display("start at edge %0d, window %0d", edge_cnt, m_window);
   endtask

   task automatic do_hit();
      hit_pulse = 1'b1;
      step();
      hit_pulse = 1'b0;
      exp_q.delete();
      if (enable) begin
         m_hits++;
         if (m_hits == 5) begin
            m_hits = 0;
            if (m_level < 15) m_level++;
            m_window = (m_window < 200 + 50) ? 200 : m_window - 50;
         end
      end
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
      check("drain_pending", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int t0;
      int e2;

      // Reset state
      repeat (3) step();
      check("rst_window", window, 1000);
      check("rst_level", level, 0);
      check("rst_running", running, 0);
      check("rst_timeout", timeout_pulse, 0);
      rst_n = 1'b1;
      enable = 1'b1;
      while (edge_cnt < 9) step();

      // Plain timeout after full window
      pulse_start();
      check("running_after_start", running, 1);
      wait_drain(1100);
      check("running_after_timeout", running, 0);

      // Hit cancels the countdown
      pulse_start();
      repeat (299) step();
      t0 = n_timeouts;
      do_hit();
      check("running_after_hit", running, 0);
      repeat (1100) step();
      check("no_timeout_after_hit", n_timeouts - t0, 0);

      // Level-ups to saturation
      for (int i = 1; i < 80; i++) begin
         pulse_start();
         do_hit();
         if (i == 4) begin
            check("level_after_5", level, m_level);
            check("window_after_5", window, m_window);
            check("window_950", window, 950);
         end
      end
      check("level_sat", level, 15);
      check("window_floor", window, 200);
      check("model_window", window, m_window);
      pulse_start();
      wait_drain(300);

      // Hit on the expiry cycle suppresses the timeout
      t0 = n_timeouts;
      pulse_start();
      repeat (m_window - 1) step();
      do_hit();
      repeat (10) step();
      check("hit_on_expiry", n_timeouts - t0, 0);
      check("running_hit_expiry", running, 0);

      // Restart mid-run
      pulse_start();
      repeat (50) step();
      pulse_start();
      e2 = exp_q[0];
      check("restart_expect", e2 - edge_cnt, 200);
      wait_drain(300);

      // Enable drop mid-run at level 3
      enable = 1'b0;
      step();
      model_clear();
      enable = 1'b1;
      repeat (15) do_hit();
      check("level_3", level, 3);
      check("window_850", window, 850);
      pulse_start();
      repeat (100) step();
      t0 = n_timeouts;
      enable = 1'b0;
      step();
      exp_q.delete();
      model_clear();
      check("en_low_running", running, 0);
      check("en_low_window", window, 1000);
      check("en_low_level", level, 0);
      repeat (20) step();
      check("en_low_no_pulse", n_timeouts - t0, 0);
      enable = 1'b1;

      // Asynchronous reset mid-run
      repeat (5) do_hit();
      check("window_pre_rst", window, 950);
      pulse_start();
      repeat (20) step();
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      model_clear();
      check("arst_running", running, 0);
      check("arst_window", window, 1000);
      check("arst_level", level, 0);
      check("arst_timeout", timeout_pulse, 0);
      repeat (3) step();
      rst_n = 1'b1;
      step();

`ifdef MOLE_TIMER_PAUSE_EN
      // Pause delays the timeout by the paused cycle count
      pulse_start();
      repeat (100) step();
      pause = 1'b1;
      repeat (100) step();
      pause = 1'b0;
      exp_q[0] = exp_q[0] + 100;
      wait_drain(1200);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
